// File: rtl/issue_dispatch_pkg.sv
// rtl/issue_dispatch_pkg.sv - shared pipeline types and classification helpers for issue_dispatch
package issue_dispatch_pkg;

  localparam int REG_W   = 5;
  localparam int SB_REGS = 32;

  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_MUL    = 3'd3,
    OP_DIV    = 3'd4,
    OP_BRANCH = 3'd5
  } op_e;

  typedef struct packed {
    op_e op;
  } decode_info_t;

  typedef struct packed {
    logic [31:0]                 pc;
    logic [15:0]                 imm;
    decode_info_t                dec;
    logic [REG_W-1:0]            w_reg;
    logic [1:0][REG_W-1:0]       r_reg;
  } inst_t;

  typedef logic [SB_REGS-1:0] scoreboard_t;

  function automatic logic is_long_latency(decode_info_t d);
    return (d.op == OP_LOAD) || (d.op == OP_MUL) || (d.op == OP_DIV);
  endfunction

  function automatic logic is_branch(decode_info_t d);
    return d.op == OP_BRANCH;
  endfunction

endpackage

// File: rtl/issue_dispatch_scoreboard.sv
// rtl/issue_dispatch_scoreboard.sv - long-latency pending-register bits with set/clear/flush and lookup port
module issue_scoreboard
  import issue_dispatch_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_LK   = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_flush,
  input  logic                          i_set_en,
  input  logic [REG_W-1:0]              i_set_reg,
  input  logic                          i_clr_en,
  input  logic [REG_W-1:0]              i_clr_reg,
  input  logic [NUM_LK-1:0][REG_W-1:0]  i_lookup,
  output logic [NUM_LK-1:0]             o_busy
);

  logic [NUM_REGS-1:0] r_pend;
  logic [NUM_REGS-1:0] w_pend_next;

  // Set is applied after clear so a same-cycle reissue keeps the register pending.
  always_comb begin
    w_pend_next = r_pend;
    if (i_clr_en) w_pend_next[i_clr_reg] = 1'b0;
    if (i_set_en) w_pend_next[i_set_reg] = 1'b1;
    w_pend_next[0] = 1'b0;
    if (i_flush) w_pend_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= w_pend_next;
  end

  always_comb begin
    o_busy = '0;
    for (int k = 0; k < NUM_LK; k++) begin
      o_busy[k] = (i_lookup[k] != '0) && r_pend[i_lookup[k]];
    end
  end

endmodule

// File: rtl/issue_dispatch.sv
// rtl/issue_dispatch.sv - pair issue decision, dispatch register and scoreboard owner
// ISSUE_DUAL_EN enables slot-1 issue; without it only slot 0 ever issues.
module issue_dispatch
  import issue_dispatch_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  inst_t [1:0]      inst_i,
  input  logic  [1:0]      inst_valid_i,
  output logic  [1:0]      issue_num_o,
  output logic             backend_stall_o,
  input  logic             ex_stall_i,
  input  logic             flush_i,
  input  logic             wb_valid_i,
  input  logic  [4:0]      wb_reg_i,
  output inst_t [1:0]      inst_o,
  output logic  [1:0]      inst_valid_o
);

`ifdef ISSUE_DUAL_EN
  localparam int N_LK = 6;
`else
  localparam int N_LK = 3;
`endif

  logic [N_LK-1:0][REG_W-1:0] w_lookup;
  logic [N_LK-1:0]            w_busy;
  logic                       w_go;
  logic                       w_issue0;
  logic                       w_issue1;
  logic                       w_set0;
  logic                       w_set_en;
  logic [REG_W-1:0]           w_set_reg;
  inst_t [1:0]                r_inst;
  logic  [1:0]                r_valid;

  assign w_lookup[2:0] = {inst_i[0].w_reg, inst_i[0].r_reg[1], inst_i[0].r_reg[0]};
  assign w_go          = ~ex_stall_i & ~flush_i & inst_valid_i[0];
  assign w_issue0      = w_go & ~(|w_busy[2:0]);
  assign w_set0        = w_issue0 & is_long_latency(inst_i[0].dec) & (inst_i[0].w_reg != '0);

`ifdef ISSUE_DUAL_EN
  logic w_raw;
  logic w_waw;
  logic w_set1;

  assign w_lookup[5:3] = {inst_i[1].w_reg, inst_i[1].r_reg[1], inst_i[1].r_reg[0]};
  assign w_raw = (inst_i[0].w_reg != '0) &&
                 ((inst_i[1].r_reg[0] == inst_i[0].w_reg) || (inst_i[1].r_reg[1] == inst_i[0].w_reg));
  assign w_waw = (inst_i[0].w_reg != '0) && (inst_i[1].w_reg == inst_i[0].w_reg);
  assign w_issue1 = w_issue0 & inst_valid_i[1] & ~(|w_busy[5:3]) & ~w_raw & ~w_waw
                  & ~(is_long_latency(inst_i[0].dec) & is_long_latency(inst_i[1].dec))
                  & ~is_branch(inst_i[0].dec);
  assign w_set1    = w_issue1 & is_long_latency(inst_i[1].dec) & (inst_i[1].w_reg != '0);
  // Only one long-latency op can issue per cycle, so at most one set is live.
  assign w_set_en  = w_set0 | w_set1;
  assign w_set_reg = w_set1 ? inst_i[1].w_reg : inst_i[0].w_reg;
`else
  logic w_unused_slot1;

  assign w_issue1       = 1'b0;
  assign w_unused_slot1 = inst_valid_i[1];
  assign w_set_en       = w_set0;
  assign w_set_reg      = inst_i[0].w_reg;
`endif

  issue_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_LK   (N_LK)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (flush_i),
    .i_set_en  (w_set_en),
    .i_set_reg (w_set_reg),
    .i_clr_en  (wb_valid_i),
    .i_clr_reg (wb_reg_i),
    .i_lookup  (w_lookup),
    .o_busy    (w_busy)
  );

  assign issue_num_o     = {w_issue1, w_issue0 & ~w_issue1};
  assign backend_stall_o = ex_stall_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst  <= '0;
      r_valid <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
    end else if (!ex_stall_i) begin
      r_inst  <= inst_i;
      r_valid <= {w_issue1, w_issue0};
    end
  end

  assign inst_o       = r_inst;
  assign inst_valid_o = r_valid;

endmodule

// File: doc/issue_dispatch.md
# issue_dispatch

- Back-end consumer of the instruction-FIFO read port.
- Each cycle, looks at the two head instructions presented by the front end and decides how many to pop (0, 1 or 2) using intra-pair and scoreboard hazard rules.
- Latches the issued pair into a one-stage dispatch register that feeds execute.
- Owns the long-latency register scoreboard that gates issue.

## Interface
Parameters:
- NUM_REGS, 32, architectural GPR count (scoreboard width; r0 never tracked)

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- inst_i  in  inst_t[1:0]  head instructions from the front-end FIFO
- inst_valid_i  in  2  per-slot valid; slot 1 valid implies slot 0 valid
- issue_num_o  out  2  number to pop this cycle (0/1/2), combinational
- backend_stall_o  out  1  drives the front end's read-ready inhibit; equals ex_stall_i
- ex_stall_i  in  1  execute stage cannot accept; hold dispatch register
- flush_i  in  1  redirect; kill dispatch register and scoreboard
- wb_valid_i  in  1  long-latency writeback completes
- wb_reg_i  in  5  register written by that writeback
- inst_o  out  inst_t[1:0]  registered issued pair
- inst_valid_o  out  2  registered per-slot valid

## Operation
Per-slot hazard checks:
- rs = the two r_reg entries, rd = w_reg; register 0 is never a hazard.
- Slot 0 is blocked if any nonzero rs or rd has its pending bit set.
- Slot 1 is blocked if any of:
  - slot 0 not issuing
  - inst_valid_i[1] = 0
  - any slot-1 rs or rd pending
  - RAW: slot-1 rs equals slot-0 rd ≠ 0
  - WAW: slot-1 rd equals slot-0 rd ≠ 0
  - both slots long-latency (single long-latency port)
  - slot 0 is a branch (predict-redirect boundary)

Issue count:
- issue_num_o = 0 when ex_stall_i, flush_i or ~inst_valid_i[0]; otherwise 1 + (slot 1 issuable).

Scoreboard (NUM_REGS pending bits):
- Set rd on issue of a long-latency instruction with rd ≠ 0.
- Clear wb_reg_i on wb_valid_i.
- Same register set and cleared in the same cycle: set wins.
- Pending bits are read from the current-cycle state. There is no writeback bypass: a consumer issues the cycle after the clear.
- flush_i clears all bits (all in-flight ops are killed).

Dispatch register:
- ex_stall_i: hold contents.
- Otherwise: load the issued slots; unissued slots get valid = 0.
- Slot compaction is not needed, because slot 1 issues only with slot 0.

## Timing
- Reset: inst_valid_o = 0, inst_o = 0, scoreboard = 0. issue_num_o is 0 while inst_valid_i = 0.
- Latency: an instruction popped in cycle N appears on inst_o in cycle N+1.
- Front-end handshake:
  - The FIFO removes exactly issue_num_o entries at the clock edge.
  - issue_num_o never exceeds popcount(inst_valid_i).
  - issue_num_o is 0 whenever backend_stall_o = 1.
- flush_i has priority over ex_stall_i and over issue:
  - inst_valid_o = 0 next cycle
  - scoreboard = 0 next cycle
  - issue_num_o = 0 in the flush cycle
- A writeback arriving during ex_stall_i still clears its pending bit.
- Asynchronous reset mid-operation drops all in-flight state immediately.

## Configuration
- ISSUE_DUAL_EN defined: the dual-issue rules above apply.
- ISSUE_DUAL_EN undefined:
  - slot 1 is never issued; issue_num_o ∈ {0,1}
  - inst_valid_o[1] is constant 0
  - the slot-1 hazard logic is not compiled
  - scoreboard behaviour is unchanged

## Structure
- Shared pipeline package gains:
  - is_long_latency(decode_info_t) for load/mul/div classification
  - is_branch(decode_info_t)
  - the scoreboard vector typedef
- One sub-module: issue_scoreboard, holding the pending bits with set/clear/flush and the lookup port.

## Test plan
- Reset, then present two independent ALU ops (rd r4, r5; rs r1, r2) -> issue_num_o = 2; next cycle inst_valid_o = 2'b11 with matching pc.
- RAW pair: slot 0 writes r6, slot 1 reads r6 -> issue_num_o = 1. Next cycle the FIFO shifts, slot 0 reads r6 -> issue_num_o ≥ 1.
- Load to r7, then a consumer of r7:
  - consumer is blocked (issue_num_o = 0) until wb_valid_i with wb_reg_i = 7
  - the consumer issues the following cycle
- Assert ex_stall_i for 3 cycles with valid input -> issue_num_o = 0, backend_stall_o = 1, inst_o held constant.
- Pending r9, then flush_i together with ex_stall_i:
  - inst_valid_o = 0 next cycle
  - the r9 consumer issues immediately afterwards
- Same-cycle writeback of r8 and issue of a new load to r8 -> r8 remains pending. ISSUE_DUAL_EN undefined build -> issue_num_o never 2.
